// File: rtl/mips_ctrl_alu_unit.sv
// rtl/mips_ctrl_alu_unit.sv - main control decoder, ALU control decoder and 32-bit ALU with registered outputs
//
// Purpose: decodes the ID-stage opcode into datapath control bits and, in
// parallel, decodes ALUOp/funct for the EX stage and evaluates the ALU. Every
// output is a flop on clock_in, so all results appear one cycle after their
// inputs.
//
// Optional build macro: IMM_ARITH_EN (adds addi/ori decode; ALUOp 11 becomes or).
//
// Ports:
//   clock_in   - clock, rising edge
//   reset      - synchronous, active-low reset
//   op_code    - instruction[31:26] from IF/ID
//   ex_alu_op  - ALUOp held in ID/EX
//   funct      - instruction[5:0] held in ID/EX
//   input1     - ALU operand A
//   input2     - ALU operand B
//   jump, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
//   branch, alu_op - registered main-decode control outputs
//   alu_ctr    - registered decoded ALU operation (observation only)
//   alu_res    - registered ALU result
//   zero       - registered (alu_res == 0)
module mips_ctrl_alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic [5:0]       op_code,
    input  logic [1:0]       ex_alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             jump,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic [1:0]       alu_op,
    output logic [3:0]       alu_ctr,
    output logic [WIDTH-1:0] alu_res,
    output logic             zero
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef IMM_ARITH_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    logic             jump_d, reg_dst_d, alu_src_d, mem_to_reg_d;
    logic             reg_write_d, mem_read_d, mem_write_d, branch_d;
    logic [1:0]       alu_op_d;
    logic [3:0]       alu_ctr_d;
    logic [WIDTH-1:0] alu_res_d;
    logic             zero_d;

    logic             jump_q, reg_dst_q, alu_src_q, mem_to_reg_q;
    logic             reg_write_q, mem_read_q, mem_write_q, branch_q;
    logic [1:0]       alu_op_q;
    logic [3:0]       alu_ctr_q;
    logic [WIDTH-1:0] alu_res_q;
    logic             zero_q;

    // Main decode: unknown opcodes fall through to all-zero (a nop).
    always_comb begin
        jump_d       = 1'b0;
        reg_dst_d    = 1'b0;
        alu_src_d    = 1'b0;
        mem_to_reg_d = 1'b0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        branch_d     = 1'b0;
        alu_op_d     = 2'b00;
        case (op_code)
            OP_RTYPE: begin
                reg_dst_d   = 1'b1;
                reg_write_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            OP_LW: begin
                alu_src_d    = 1'b1;
                mem_to_reg_d = 1'b1;
                reg_write_d  = 1'b1;
                mem_read_d   = 1'b1;
            end
            OP_SW: begin
                alu_src_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            OP_BEQ: begin
                branch_d = 1'b1;
                alu_op_d = 2'b01;
            end
            OP_J: jump_d = 1'b1;
`ifdef IMM_ARITH_EN
            OP_ADDI: begin
                alu_src_d   = 1'b1;
                reg_write_d = 1'b1;
            end
            OP_ORI: begin
                alu_src_d   = 1'b1;
                reg_write_d = 1'b1;
                alu_op_d    = 2'b11;
            end
`endif
            default: ;
        endcase
    end

    // ALU control decode.
    always_comb begin
        alu_ctr_d = ALU_AND;
        case (ex_alu_op)
            2'b00: alu_ctr_d = ALU_ADD;
            2'b01: alu_ctr_d = ALU_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: alu_ctr_d = ALU_ADD;
                    6'b100010: alu_ctr_d = ALU_SUB;
                    6'b100100: alu_ctr_d = ALU_AND;
                    6'b100101: alu_ctr_d = ALU_OR;
                    6'b101010: alu_ctr_d = ALU_SLT;
                    6'b100111: alu_ctr_d = ALU_NOR;
                    default:   alu_ctr_d = ALU_AND;
                endcase
            end
`ifdef IMM_ARITH_EN
            default: alu_ctr_d = ALU_OR;
`else
            default: alu_ctr_d = ALU_SUB;
`endif
        endcase
    end

    // ALU works from the freshly decoded alu_ctr_d, not the registered copy.
    always_comb begin
        alu_res_d = '0;
        case (alu_ctr_d)
            ALU_AND: alu_res_d = input1 & input2;
            ALU_OR:  alu_res_d = input1 | input2;
            ALU_ADD: alu_res_d = input1 + input2;
            ALU_SUB: alu_res_d = input1 - input2;
            ALU_SLT: alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
            ALU_NOR: alu_res_d = ~(input1 | input2);
            default: alu_res_d = '0;
        endcase
        zero_d = (alu_res_d == '0);
    end

    always_ff @(posedge clock_in) begin
        if (!reset) begin
            jump_q       <= 1'b0;
            reg_dst_q    <= 1'b0;
            alu_src_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            alu_op_q     <= 2'b00;
            alu_ctr_q    <= 4'b0000;
            alu_res_q    <= '0;
            zero_q       <= 1'b0;
        end else begin
            jump_q       <= jump_d;
            reg_dst_q    <= reg_dst_d;
            alu_src_q    <= alu_src_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            branch_q     <= branch_d;
            alu_op_q     <= alu_op_d;
            alu_ctr_q    <= alu_ctr_d;
            alu_res_q    <= alu_res_d;
            zero_q       <= zero_d;
        end
    end

    assign jump       = jump_q;
    assign reg_dst    = reg_dst_q;
    assign alu_src    = alu_src_q;
    assign mem_to_reg = mem_to_reg_q;
    assign reg_write  = reg_write_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign branch     = branch_q;
    assign alu_op     = alu_op_q;
    assign alu_ctr    = alu_ctr_q;
    assign alu_res    = alu_res_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_mips_ctrl_alu_unit.sv
// tb/tb_mips_ctrl_alu_unit.sv - self-checking bench for mips_ctrl_alu_unit
module tb_mips_ctrl_alu_unit;

    logic        clock_in = 1'b0;
    logic        reset;
    logic [5:0]  op_code;
    logic [1:0]  ex_alu_op;
    logic [5:0]  funct;
    logic [31:0] input1, input2;
    logic        jump, reg_dst, alu_src, mem_to_reg, reg_write;
    logic        mem_read, mem_write, branch, zero;
    logic [1:0]  alu_op;
    logic [3:0]  alu_ctr;
    logic [31:0] alu_res;

    int checks = 0;
    int errors = 0;

    always #5 clock_in = ~clock_in;

    mips_ctrl_alu_unit #(.WIDTH(32)) dut (
        .clock_in(clock_in), .reset(reset), .op_code(op_code),
        .ex_alu_op(ex_alu_op), .funct(funct), .input1(input1), .input2(input2),
        .jump(jump), .reg_dst(reg_dst), .alu_src(alu_src),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .alu_op(alu_op),
        .alu_ctr(alu_ctr), .alu_res(alu_res), .zero(zero)
    );

    // Reference control vector {jump,reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,alu_op}
    function automatic logic [9:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'd0:  return 10'b0_1_0_0_1_0_0_0_10;
            6'd35: return 10'b0_0_1_1_1_1_0_0_00;
            6'd43: return 10'b0_0_1_0_0_0_1_0_00;
            6'd4:  return 10'b0_0_0_0_0_0_0_1_01;
            6'd2:  return 10'b1_0_0_0_0_0_0_0_00;
`ifdef IMM_ARITH_EN
            6'd8:  return 10'b0_0_1_0_1_0_0_0_00;
            6'd13: return 10'b0_0_1_0_1_0_0_0_11;
`endif
            default: return 10'b0;
        endcase
    endfunction

    function automatic logic [3:0] ref_alu_ctr(input logic [1:0] aop, input logic [5:0] f);
        if (aop == 2'd0) return 4'd2;
        if (aop == 2'd1) return 4'd6;
`ifdef IMM_ARITH_EN
        if (aop == 2'd3) return 4'd1;
`else
        if (aop == 2'd3) return 4'd6;
`endif
        case (f)
            6'd32: return 4'd2;
            6'd34: return 4'd6;
            6'd36: return 4'd0;
            6'd37: return 4'd1;
            6'd42: return 4'd7;
            6'd39: return 4'd12;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (c)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            4'd6:  return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
            4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd12: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    // Compute expectations from the inputs present now, clock once, then compare.
    task automatic step(input string tag);
        logic [9:0]  e_ctrl;
        logic [3:0]  e_ctr;
        logic [31:0] e_res;
        logic        e_zero;
        if (!reset) begin
            e_ctrl = '0; e_ctr = '0; e_res = '0; e_zero = 1'b0;
        end else begin
            e_ctrl = ref_ctrl(op_code);
            e_ctr  = ref_alu_ctr(ex_alu_op, funct);
            e_res  = ref_alu(e_ctr, input1, input2);
            e_zero = (e_res == 32'd0);
        end
        @(posedge clock_in);
        #1;
        checks++;
        assert ({jump, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op} === e_ctrl)
            else begin errors++; $error("FAIL %s ctrl got %b exp %b", tag,
                {jump, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}, e_ctrl); end
        checks++;
        assert (alu_ctr === e_ctr)
            else begin errors++; $error("FAIL %s alu_ctr got %b exp %b", tag, alu_ctr, e_ctr); end
        checks++;
        assert (alu_res === e_res)
            else begin errors++; $error("FAIL %s alu_res got %h exp %h", tag, alu_res, e_res); end
        checks++;
        assert (zero === e_zero)
            else begin errors++; $error("FAIL %s zero got %b exp %b", tag, zero, e_zero); end
    endtask

    task automatic set_in(input logic [5:0] op, input logic [1:0] aop, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b);
        op_code = op; ex_alu_op = aop; funct = f; input1 = a; input2 = b;
    endtask

    logic [5:0] op_list [8];
    logic [5:0] fn_list [7];

    initial begin
        op_list = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd13, 6'd63};
        fn_list = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39, 6'd0};

        // Reset held for two cycles with random inputs.
        reset = 1'b0;
        set_in(6'd0, 2'b10, 6'd32, $urandom, $urandom);
        step("reset0");
        set_in(6'd35, 2'b00, 6'd0, 32'd1, 32'd2);
        step("reset1");
        reset = 1'b1;

        // Opcode sweep.
        set_in(6'b000000, 2'b10, 6'b100000, 32'd7, 32'd5); step("op_rtype");
        set_in(6'b100011, 2'b00, 6'd0, 32'd100, 32'd4);    step("op_lw");
        set_in(6'b101011, 2'b00, 6'd0, 32'd8, 32'd8);      step("op_sw");
        set_in(6'b000100, 2'b01, 6'd0, 32'h1234, 32'h1234); step("op_beq");
        set_in(6'b000010, 2'b00, 6'd0, 32'hFFFFFFFF, 32'd1); step("op_j_wrap");
        set_in(6'b111111, 2'b11, 6'd0, 32'd9, 32'd3);      step("op_nop");
        set_in(6'b001000, 2'b00, 6'd0, 32'd3, 32'd4);      step("op_addi");
        set_in(6'b001101, 2'b11, 6'd0, 32'hF0, 32'h0F);    step("op_ori");

        // R-type funct sweep with 7 and 5.
        foreach (fn_list[i]) begin
            set_in(6'd0, 2'b10, fn_list[i], 32'd7, 32'd5);
            step($sformatf("funct_%0d", i));
        end

        // Signed slt both ways.
        set_in(6'd0, 2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1); step("slt_neg");
        set_in(6'd0, 2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF); step("slt_swap");

        // Mid-stream reset after a non-zero result.
        set_in(6'd35, 2'b00, 6'd0, 32'd10, 32'd20); step("pre_reset");
        reset = 1'b0;
        step("mid_reset");
        reset = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            logic [5:0]  op, f;
            logic [31:0] a, b;
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : op_list[$urandom_range(0, 7)];
            f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 6)];
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
            reset = ($urandom_range(0, 15) != 0);
            set_in(op, 2'($urandom), f, a, b);
            step($sformatf("rand_%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
